// File: rtl/pattern_count_latch.sv
// Serial pattern detector feeding a saturating 4-digit BCD counter whose value
// and overflow flag are latched for display at the end of each counting window.
module pattern_count_latch #(
  parameter logic [3:0] PATTERN = 4'b1011,
  parameter int         OVERLAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       period_end,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic       match,
  output logic       sat
);

  typedef enum logic [2:0] {FILL0, FILL1, FILL2, FILL3, RUN} fill_e;

  fill_e            state_q;
  logic [3:0]       hist_q, hist_d;
  logic             match_q;
  logic [3:0][3:0]  cnt_q, cnt_d;
  logic             sat_int_q, sat_d;
  logic [3:0][3:0]  hex_q;
  logic             sat_q;

  logic             det;
  logic             all_nine;
  logic             carry;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    hist_d   = bit_valid ? {hist_q[2:0], bit_in} : hist_q;
    det      = bit_valid && ((state_q == FILL3) || (state_q == RUN)) && (hist_d == PATTERN);
    all_nine = (cnt_q == 16'h9999);
    cnt_d    = cnt_q;
    sat_d    = sat_int_q;
    carry    = 1'b1;
    if (det) begin
      if (all_nine) begin
        sat_d = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (carry) begin
            if (cnt_q[i] == 4'd9) begin
              cnt_d[i] = 4'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 4'd1;
              carry    = 1'b0;
            end
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FILL0;
      hist_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
      sat_int_q <= 1'b0;
      hex_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      match_q <= det;
      if (bit_valid) begin
        hist_q <= hist_d;
        case (state_q)
          FILL0:   state_q <= FILL1;
          FILL1:   state_q <= FILL2;
          FILL2:   state_q <= FILL3;
          FILL3,
          RUN:     state_q <= (det && (OVERLAP == 0)) ? FILL0 : RUN;
          default: state_q <= FILL0;
        endcase
      end
      // The window tick latches the count including any same-edge increment.
      if (period_end) begin
        hex_q     <= cnt_d;
        sat_q     <= sat_d;
        cnt_q     <= '0;
        sat_int_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        sat_int_q <= sat_d;
      end
    end
  end

  assign hex0  = hex_q[0];
  assign hex1  = hex_q[1];
  assign hex2  = hex_q[2];
  assign hex3  = hex_q[3];
  assign match = match_q;
  assign sat   = sat_q;

endmodule
